ddr_burst_scheduler: RTL and testbench



---
 rtl/ddr_burst_scheduler_pkg.sv | 23 ++
 rtl/ddr_burst_scheduler_if.sv | 24 ++
 rtl/ddr_burst_scheduler_addr_ptr.sv | 83 ++++++++
 rtl/ddr_burst_scheduler.sv | 133 +++++++++++++
 tb/tb_ddr_burst_scheduler.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_burst_scheduler_pkg.sv
// Shared types for the DDR burst scheduler: FSM states, grant sides and
// burst-size helper.
package ddr_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT
    } sched_state_t;

    typedef enum logic {
        WRITE,
        READ
    } grant_t;

    function automatic int burst_bytes(input int burst_len, input int data_w);
        return burst_len * data_w / 8;
    endfunction

endpackage

// File: rtl/ddr_burst_scheduler_if.sv
// Command/completion handshake between the burst scheduler and the AXI
// write and read engines.
interface ddr_burst_scheduler_if #(
    parameter int ADDR_W = 30
);
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_cmd_addr;
    logic              wr_cmd_done;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_addr;
    logic              rd_cmd_done;

    modport master (
        output wr_cmd_valid, wr_cmd_addr, rd_cmd_valid, rd_cmd_addr,
        input  wr_cmd_ready, wr_cmd_done, rd_cmd_ready, rd_cmd_done
    );

    modport slave (
        input  wr_cmd_valid, wr_cmd_addr, rd_cmd_valid, rd_cmd_addr,
        output wr_cmd_ready, wr_cmd_done, rd_cmd_ready, rd_cmd_done
    );
endinterface

// File: rtl/ddr_burst_scheduler_addr_ptr.sv
// Region base + burst offset pointer with deferred base reload and wrap pulse.
// One instance serves the write path, another the read path.
module ddr_addr_ptr
    import ddr_sched_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int BURST_BYTES  = 256,
    parameter int REGION_BYTES = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              hold,
    input  logic              done,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              wrap
);

    localparam int PTR_W = $clog2(REGION_BYTES);
    localparam int BLK_W = $clog2(BURST_BYTES);
    localparam logic [PTR_W:0] REGION_END = (PTR_W + 1)'(REGION_BYTES);
    localparam logic [PTR_W:0] STEP       = (PTR_W + 1)'(BURST_BYTES);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] pend_base_q;
    logic              pend_q;
    logic [PTR_W-1:0]  ptr_q;

    logic              apply_now;
    logic [ADDR_W-1:0] eff_base;
    logic [PTR_W-1:0]  eff_ptr;
    logic [ADDR_W-1:0] sum;
    logic [PTR_W:0]    ptr_inc;

    // The address offered to the top already reflects a reload taking effect
    // on this edge, so a grant coinciding with a reload uses the new base.
    always_comb begin
        apply_now = !hold && (load || pend_q);
        eff_base  = base_q;
        eff_ptr   = ptr_q;
        if (apply_now) begin
            eff_base = load ? load_addr : pend_base_q;
            eff_ptr  = '0;
        end
        sum      = eff_base + ADDR_W'(eff_ptr);
        cmd_addr = {sum[ADDR_W-1:BLK_W], {BLK_W{1'b0}}};
        ptr_inc  = {1'b0, ptr_q} + STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            pend_base_q <= '0;
            pend_q      <= 1'b0;
            ptr_q       <= '0;
            wrap        <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (done) begin
                // A reload queued during the burst replaces the increment.
                if (load || pend_q) begin
                    base_q <= load ? load_addr : pend_base_q;
                    ptr_q  <= '0;
                    pend_q <= 1'b0;
                end else if (ptr_inc == REGION_END) begin
                    ptr_q <= '0;
                    wrap  <= 1'b1;
                end else begin
                    ptr_q <= ptr_inc[PTR_W-1:0];
                end
            end else if (apply_now) begin
                base_q <= eff_base;
                ptr_q  <= '0;
                pend_q <= 1'b0;
            end else if (load) begin
                pend_q      <= 1'b1;
                pend_base_q <= load_addr;
            end
        end
    end

endmodule

// File: rtl/ddr_burst_scheduler.sv
// Round-robin burst scheduler sharing one AXI master between the write and
// read paths; issues one command at a time and waits for its completion.
module ddr_burst_scheduler
    import ddr_sched_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 30,
    parameter int C_M_AXI_DATA_WIDTH = 128,
    parameter int BURST_LEN          = 16,
    parameter int REGION_BYTES       = 32'h0010_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          init_calib_complete,
    input  logic                          wr_begin,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] wr_addr_begin,
    input  logic                          rd_enable,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] rd_addr_begin,
    input  logic                          wr_req,
    input  logic                          rd_req,
    ddr_burst_scheduler_if.master         bus,
    output logic                          busy,
    output logic                          wr_wrap,
    output logic                          rd_wrap
);

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int BURST_BYTES = burst_bytes(BURST_LEN, C_M_AXI_DATA_WIDTH);

    sched_state_t state_q, state_d;
    grant_t       last_grant_q;
    logic         rd_enable_q;
    logic [AW-1:0] wr_addr_q, rd_addr_q;
    logic [AW-1:0] wr_next_addr, rd_next_addr;

    logic wr_cand, rd_cand;
    logic wr_hold, rd_hold;
    logic wr_done, rd_done;
    logic rd_load;

    assign wr_cand = wr_req;
    assign rd_cand = rd_req && rd_enable;
    assign wr_hold = (state_q == WR_ISSUE) || (state_q == WR_WAIT);
    assign rd_hold = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
    // Completions outside the matching wait state are stray and dropped.
    assign wr_done = bus.wr_cmd_done && (state_q == WR_WAIT);
    assign rd_done = bus.rd_cmd_done && (state_q == RD_WAIT);
    assign rd_load = rd_enable && !rd_enable_q;

    ddr_addr_ptr #(
        .ADDR_W      (AW),
        .BURST_BYTES (BURST_BYTES),
        .REGION_BYTES(REGION_BYTES)
    ) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wr_begin),
        .load_addr(wr_addr_begin),
        .hold     (wr_hold),
        .done     (wr_done),
        .cmd_addr (wr_next_addr),
        .wrap     (wr_wrap)
    );

    ddr_addr_ptr #(
        .ADDR_W      (AW),
        .BURST_BYTES (BURST_BYTES),
        .REGION_BYTES(REGION_BYTES)
    ) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rd_load),
        .load_addr(rd_addr_begin),
        .hold     (rd_hold),
        .done     (rd_done),
        .cmd_addr (rd_next_addr),
        .wrap     (rd_wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (init_calib_complete) state_d = ARB;
            ARB: begin
                if (!init_calib_complete)                                 state_d = IDLE;
                else if (wr_cand && (!rd_cand || last_grant_q == READ))   state_d = WR_ISSUE;
                else if (rd_cand)                                         state_d = RD_ISSUE;
            end
            // An accepted command must be seen through, so ready wins over
            // calibration loss or read withdrawal.
            WR_ISSUE: begin
                if (bus.wr_cmd_ready)          state_d = WR_WAIT;
                else if (!init_calib_complete) state_d = IDLE;
            end
            WR_WAIT: if (bus.wr_cmd_done) state_d = init_calib_complete ? ARB : IDLE;
            RD_ISSUE: begin
                if (bus.rd_cmd_ready)          state_d = RD_WAIT;
                else if (!init_calib_complete) state_d = IDLE;
                else if (!rd_enable)           state_d = ARB;
            end
            RD_WAIT: if (bus.rd_cmd_done) state_d = init_calib_complete ? ARB : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= READ;
            rd_enable_q  <= 1'b0;
            busy         <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
        end else begin
            state_q     <= state_d;
            rd_enable_q <= rd_enable;
            busy        <= !(state_d inside {IDLE, ARB});
            if (state_q == ARB && state_d == WR_ISSUE) begin
                wr_addr_q    <= wr_next_addr;
                last_grant_q <= WRITE;
            end
            if (state_q == ARB && state_d == RD_ISSUE) begin
                rd_addr_q    <= rd_next_addr;
                last_grant_q <= READ;
            end
        end
    end

    assign bus.wr_cmd_valid = (state_q == WR_ISSUE);
    assign bus.rd_cmd_valid = (state_q == RD_ISSUE);
    assign bus.wr_cmd_addr  = wr_addr_q;
    assign bus.rd_cmd_addr  = rd_addr_q;

endmodule

// File: tb/tb_ddr_burst_scheduler.sv
// Bench for ddr_burst_scheduler with a 1 KiB region (four 256-byte bursts),
// emulating both AXI engines and predicting grants/addresses from a model.
module tb_ddr_burst_scheduler;

    localparam int AW = 30;
    localparam int BB = 256;
    localparam int RB = 1024;
    localparam int NB = RB / BB;
    localparam logic [AW-1:0] MASK = 30'h3FFF_FF00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          calib = 1'b0;
    logic          wr_begin = 1'b0;
    logic [AW-1:0] wr_addr_begin = '0;
    logic          rd_enable = 1'b0;
    logic [AW-1:0] rd_addr_begin = '0;
    logic          wr_req = 1'b0;
    logic          rd_req = 1'b0;
    logic          busy, wr_wrap, rd_wrap;

    ddr_burst_scheduler_if #(.ADDR_W(AW)) bus ();

    ddr_burst_scheduler #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(128),
        .BURST_LEN         (16),
        .REGION_BYTES      (RB)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .init_calib_complete(calib),
        .wr_begin           (wr_begin),
        .wr_addr_begin      (wr_addr_begin),
        .rd_enable          (rd_enable),
        .rd_addr_begin      (rd_addr_begin),
        .wr_req             (wr_req),
        .rd_req             (rd_req),
        .bus                (bus),
        .busy               (busy),
        .wr_wrap            (wr_wrap),
        .rd_wrap            (rd_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: base and number of bursts completed since the last load.
    logic [AW-1:0] m_wr_base, m_rd_base;
    int            m_wr_cnt, m_rd_cnt;
    bit            m_last_rd;

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int cnt);
        logic [AW-1:0] a;
        a = base + AW'((cnt % NB) * BB);
        return a & MASK;
    endfunction

    function automatic bit exp_grant_wr(input bit wr_c, input bit rd_c);
        if (wr_c && rd_c) return m_last_rd;
        return wr_c;
    endfunction

    task automatic model_reset();
        m_wr_base = '0; m_rd_base = '0;
        m_wr_cnt  = 0;  m_rd_cnt  = 0;
        m_last_rd = 1'b1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic pulse_wr_begin(input logic [AW-1:0] a);
        wr_addr_begin = a;
        wr_begin = 1'b1;
        @(negedge clk);
        wr_begin = 1'b0;
    endtask

    // Engine emulation: accept whichever command appears, then complete it.
    task automatic run_burst(input int rdy_dly, input int gap, output bit to,
                             output bit is_wr, output logic [AW-1:0] addr,
                             output bit wrap_seen);
        int n;
        to = 1'b0; is_wr = 1'b0; addr = '0; wrap_seen = 1'b0; n = 0;
        while (!bus.wr_cmd_valid && !bus.rd_cmd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.wr_cmd_valid && !bus.rd_cmd_valid) begin
            to = 1'b1;
            return;
        end
        is_wr = bus.wr_cmd_valid;
        addr  = is_wr ? bus.wr_cmd_addr : bus.rd_cmd_addr;
        repeat (rdy_dly) @(negedge clk);
        if (is_wr) bus.wr_cmd_ready = 1'b1; else bus.rd_cmd_ready = 1'b1;
        @(negedge clk);
        bus.wr_cmd_ready = 1'b0; bus.rd_cmd_ready = 1'b0;
        repeat (gap) begin
            wrap_seen |= is_wr ? wr_wrap : rd_wrap;
            @(negedge clk);
        end
        if (is_wr) bus.wr_cmd_done = 1'b1; else bus.rd_cmd_done = 1'b1;
        @(negedge clk);
        bus.wr_cmd_done = 1'b0; bus.rd_cmd_done = 1'b0;
        wrap_seen |= is_wr ? wr_wrap : rd_wrap;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.wr_cmd_valid, bus.rd_cmd_valid, busy, wr_wrap, rd_wrap} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.wr_cmd_valid, bus.rd_cmd_valid, busy, wr_wrap, rd_wrap});
        end
        n_checks++;
        if (bus.wr_cmd_addr !== '0 || bus.rd_cmd_addr !== '0) begin
            n_errors++;
            $display("FAIL reset_addr: got wr=%h rd=%h required 0", bus.wr_cmd_addr, bus.rd_cmd_addr);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_calib_gate();
        bit seen, to, is_wr, wrp;
        logic [AW-1:0] a;
        int n;
        pulse_wr_begin(30'h0100_0000);
        m_wr_base = 30'h0100_0000; m_wr_cnt = 0;
        wr_req = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.wr_cmd_valid | busy;
        end
        n_checks++;
        if (seen) begin
            n_errors++;
            $display("FAIL calib_gate_block: command/busy seen while calibration low");
        end
        calib = 1'b1;
        n = 0;
        while (!bus.wr_cmd_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!bus.wr_cmd_valid || n > 2) begin
            n_errors++;
            $display("FAIL calib_gate_latency: valid=%b after %0d cycles required 1 within 2",
                     bus.wr_cmd_valid, n);
        end
        n_checks++;
        if (bus.wr_cmd_addr !== exp_addr(m_wr_base, m_wr_cnt)) begin
            n_errors++;
            $display("FAIL calib_gate_addr: got %h required %h", bus.wr_cmd_addr,
                     exp_addr(m_wr_base, m_wr_cnt));
        end
        run_burst(0, 1, to, is_wr, a, wrp);
        wr_req = 1'b0;
        m_wr_cnt++; m_last_rd = 1'b0;
    endtask

    task automatic test_wrap();
        bit to, is_wr, wrp, ewrap;
        logic [AW-1:0] a;
        pulse_wr_begin(30'h0100_0000);
        m_wr_base = 30'h0100_0000; m_wr_cnt = 0;
        wr_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_burst($urandom_range(0, 2), $urandom_range(0, 3), to, is_wr, a, wrp);
            ewrap = ((m_wr_cnt + 1) % NB) == 0;
            n_checks++;
            if (to || !is_wr || a !== exp_addr(m_wr_base, m_wr_cnt)) begin
                n_errors++;
                $display("FAIL wrap_addr[%0d]: timeout=%b wr=%b got %h required %h",
                         k, to, is_wr, a, exp_addr(m_wr_base, m_wr_cnt));
            end
            n_checks++;
            if (wrp !== ewrap) begin
                n_errors++;
                $display("FAIL wrap_pulse[%0d]: got %b required %b", k, wrp, ewrap);
            end
            m_wr_cnt++; m_last_rd = 1'b0;
        end
        wr_req = 1'b0;
    endtask

    task automatic test_round_robin();
        bit to, is_wr, wrp, ew;
        logic [AW-1:0] a, ea;
        rd_enable = 1'b0;
        apply_reset();
        pulse_wr_begin(30'h0300_0000);
        m_wr_base = 30'h0300_0000;
        rd_addr_begin = 30'h0100_0000;
        rd_enable = 1'b1;
        m_rd_base = 30'h0100_0000; m_rd_cnt = 0;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ew = exp_grant_wr(1'b1, 1'b1);
            ea = ew ? exp_addr(m_wr_base, m_wr_cnt) : exp_addr(m_rd_base, m_rd_cnt);
            run_burst($urandom_range(0, 1), $urandom_range(0, 2), to, is_wr, a, wrp);
            n_checks++;
            if (to || is_wr !== ew || a !== ea) begin
                n_errors++;
                $display("FAIL rr_grant[%0d]: timeout=%b wr=%b addr=%h required wr=%b addr=%h",
                         k, to, is_wr, a, ew, ea);
            end
            if (ew) m_wr_cnt++; else m_rd_cnt++;
            m_last_rd = !ew;
        end
        wr_req = 1'b0; rd_req = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] a0, ea;
        bit stable, ewrap;
        int n;
        ea = exp_addr(m_wr_base, m_wr_cnt);
        wr_req = 1'b1;
        n = 0;
        while (!bus.wr_cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        a0 = bus.wr_cmd_addr;
        n_checks++;
        if (!bus.wr_cmd_valid || a0 !== ea) begin
            n_errors++;
            $display("FAIL bp_issue: valid=%b addr=%h required 1 %h", bus.wr_cmd_valid, a0, ea);
        end
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.wr_cmd_valid || bus.wr_cmd_addr !== a0) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_errors++;
            $display("FAIL bp_hold: valid/addr changed while ready low (addr=%h required %h)",
                     bus.wr_cmd_addr, a0);
        end
        bus.wr_cmd_ready = 1'b1;
        @(negedge clk);
        bus.wr_cmd_ready = 1'b0;
        wr_req = 1'b0;
        n_checks++;
        if (bus.wr_cmd_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_accept: valid=%b busy=%b required 0 1", bus.wr_cmd_valid, busy);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.wr_cmd_done = 1'b1;
        @(negedge clk);
        bus.wr_cmd_done = 1'b0;
        ewrap = ((m_wr_cnt + 1) % NB) == 0;
        n_checks++;
        if (wr_wrap !== ewrap) begin
            n_errors++;
            $display("FAIL bp_wrap: got %b required %b", wr_wrap, ewrap);
        end
        m_wr_cnt++; m_last_rd = 1'b0;
    endtask

    task automatic test_pending_reload();
        bit to, is_wr, wrp;
        logic [AW-1:0] a, ea;
        int n;
        wr_req = 1'b1;
        while (m_wr_cnt % NB != NB - 1) begin
            run_burst(0, $urandom_range(0, 2), to, is_wr, a, wrp);
            n_checks++;
            if (to || !is_wr || a !== exp_addr(m_wr_base, m_wr_cnt)) begin
                n_errors++;
                $display("FAIL reload_pre: got %h required %h", a, exp_addr(m_wr_base, m_wr_cnt));
            end
            m_wr_cnt++;
        end
        ea = exp_addr(m_wr_base, m_wr_cnt);
        n = 0;
        while (!bus.wr_cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.wr_cmd_ready = 1'b1;
        @(negedge clk);
        bus.wr_cmd_ready = 1'b0;
        pulse_wr_begin(30'h0200_0000);
        @(negedge clk);
        n_checks++;
        if (bus.wr_cmd_addr !== ea || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reload_inflight: addr=%h busy=%b required %h 1", bus.wr_cmd_addr, busy, ea);
        end
        bus.wr_cmd_done = 1'b1;
        @(negedge clk);
        bus.wr_cmd_done = 1'b0;
        n_checks++;
        if (wr_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL reload_nowrap: got %b required 0", wr_wrap);
        end
        m_wr_base = 30'h0200_0000; m_wr_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            run_burst(0, 1, to, is_wr, a, wrp);
            n_checks++;
            if (to || !is_wr || a !== exp_addr(m_wr_base, m_wr_cnt) || wrp) begin
                n_errors++;
                $display("FAIL reload_next[%0d]: got %h wrap=%b required %h 0",
                         k, a, wrp, exp_addr(m_wr_base, m_wr_cnt));
            end
            m_wr_cnt++;
        end
        wr_req = 1'b0;
        m_last_rd = 1'b0;
    endtask

    task automatic test_rd_withdraw();
        bit to, is_wr, wrp, seen;
        logic [AW-1:0] a;
        int n;
        rd_req = 1'b1;
        n = 0;
        while (!bus.rd_cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!bus.rd_cmd_valid || bus.rd_cmd_addr !== exp_addr(m_rd_base, m_rd_cnt)) begin
            n_errors++;
            $display("FAIL withdraw_issue: valid=%b addr=%h required 1 %h",
                     bus.rd_cmd_valid, bus.rd_cmd_addr, exp_addr(m_rd_base, m_rd_cnt));
        end
        rd_enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rd_cmd_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL withdraw_drop: valid=%b busy=%b required 0 0", bus.rd_cmd_valid, busy);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= bus.rd_cmd_valid | bus.wr_cmd_valid;
        end
        n_checks++;
        if (seen) begin
            n_errors++;
            $display("FAIL withdraw_idle: command issued with rd_enable low");
        end
        rd_enable = 1'b1;
        m_rd_base = rd_addr_begin; m_rd_cnt = 0;
        run_burst(0, 1, to, is_wr, a, wrp);
        n_checks++;
        if (to || is_wr || a !== exp_addr(m_rd_base, m_rd_cnt)) begin
            n_errors++;
            $display("FAIL withdraw_reissue: timeout=%b wr=%b got %h required %h",
                     to, is_wr, a, exp_addr(m_rd_base, m_rd_cnt));
        end
        m_rd_cnt++; m_last_rd = 1'b1;
        rd_req = 1'b0;
    endtask

    task automatic test_async_reset();
        bit to, is_wr, wrp;
        logic [AW-1:0] a;
        int n;
        wr_req = 1'b1;
        n = 0;
        while (!bus.wr_cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.wr_cmd_ready = 1'b1;
        @(negedge clk);
        bus.wr_cmd_ready = 1'b0;
        wr_req = 1'b0;
        pulse_wr_begin(30'h0155_0000);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre_busy: got %b required 1", busy);
        end
        rd_enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.wr_cmd_valid, bus.rd_cmd_valid, busy, wr_wrap, rd_wrap} !== 5'b0 ||
            bus.wr_cmd_addr !== '0 || bus.rd_cmd_addr !== '0) begin
            n_errors++;
            $display("FAIL areset_clear: ctrl=%b wr_addr=%h rd_addr=%h required all 0",
                     {bus.wr_cmd_valid, bus.rd_cmd_valid, busy, wr_wrap, rd_wrap},
                     bus.wr_cmd_addr, bus.rd_cmd_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        wr_req = 1'b1;
        run_burst(0, 1, to, is_wr, a, wrp);
        n_checks++;
        if (to || !is_wr || a !== exp_addr(m_wr_base, m_wr_cnt)) begin
            n_errors++;
            $display("FAIL areset_lost_load: got %h required %h", a, exp_addr(m_wr_base, m_wr_cnt));
        end
        m_wr_cnt++; m_last_rd = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic test_random();
        bit to, is_wr, wrp, wr_c, rd_c, ew, ewrap;
        logic [AW-1:0] a, ea, b;
        int c;
        rd_addr_begin = AW'($urandom);
        rd_enable = 1'b1;
        m_rd_base = rd_addr_begin; m_rd_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = AW'($urandom);
                pulse_wr_begin(b);
                m_wr_base = b; m_wr_cnt = 0;
            end
            c = $urandom_range(1, 3);
            wr_c = c[0]; rd_c = c[1];
            wr_req = wr_c; rd_req = rd_c;
            ew = exp_grant_wr(wr_c, rd_c);
            ea = ew ? exp_addr(m_wr_base, m_wr_cnt) : exp_addr(m_rd_base, m_rd_cnt);
            ewrap = ew ? (((m_wr_cnt + 1) % NB) == 0) : (((m_rd_cnt + 1) % NB) == 0);
            run_burst($urandom_range(0, 3), $urandom_range(0, 3), to, is_wr, a, wrp);
            wr_req = 1'b0; rd_req = 1'b0;
            n_checks++;
            if (to || is_wr !== ew || a !== ea || wrp !== ewrap) begin
                n_errors++;
                $display("FAIL random[%0d]: timeout=%b wr=%b addr=%h wrap=%b required wr=%b addr=%h wrap=%b",
                         k, to, is_wr, a, wrp, ew, ea, ewrap);
            end
            if (ew) m_wr_cnt++; else m_rd_cnt++;
            m_last_rd = !ew;
        end
    endtask

    initial begin
        bus.wr_cmd_ready = 1'b0; bus.wr_cmd_done = 1'b0;
        bus.rd_cmd_ready = 1'b0; bus.rd_cmd_done = 1'b0;
        model_reset();
        test_reset();
        test_calib_gate();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_pending_reload();
        test_rd_withdraw();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
